// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle core sequencer and its decoder.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_31 = 2'd2;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;

  // Path flags steer the FSM; selects go straight to the datapath.
  typedef struct packed {
    logic       need_mem;
    logic       need_wb;
    logic       sw;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       jr;
    logic       illegal;
    logic [1:0] regdst;
    logic [2:0] aluctrl;
    logic       alusrc;
    logic [1:0] memtoreg;
  } ctrl_t;

endpackage

// File: rtl/core_decode.sv
// Combinational instruction decoder: IR to path flags and datapath selects.
module core_decode
  import core_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_R: begin
        unique case (funct)
          FN_ADD: begin ctrl.need_wb = 1'b1; ctrl.aluctrl = ALU_ADD; end
          FN_SUB: begin ctrl.need_wb = 1'b1; ctrl.aluctrl = ALU_SUB; end
          FN_SLT: begin ctrl.need_wb = 1'b1; ctrl.aluctrl = ALU_SLT; end
          FN_JR:  ctrl.jr = 1'b1;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_XORI: begin
        ctrl.need_wb = 1'b1;
        ctrl.alusrc  = 1'b1;
        ctrl.regdst  = REGDST_RT;
        ctrl.aluctrl = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      OP_LW: begin
        ctrl.need_mem = 1'b1;
        ctrl.need_wb  = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regdst   = REGDST_RT;
        ctrl.memtoreg = MTR_MEM;
        ctrl.aluctrl  = ALU_ADD;
      end
      OP_SW: begin
        ctrl.need_mem = 1'b1;
        ctrl.sw       = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch  = 1'b1;
        ctrl.bne     = (opcode == OP_BNE);
        ctrl.aluctrl = ALU_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.need_wb  = 1'b1;
        ctrl.regdst   = REGDST_31;
        ctrl.memtoreg = MTR_PC;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multicycle control unit: fetch handshake, IR, FSM and PC/next-PC logic.
// Build option: CORE_SEQ_ILLEGAL_TRAP_EN makes illegal instructions halt until reset.
//
// state  | meaning
// FETCH  | request instruction at pc, latch IR when instr_valid
// DECODE | selects settle from IR; illegal retires as NOP or traps
// EXEC   | ALU operation; branches/jumps retire here
// MEM    | data memory access; SW retires here
// WB     | register write; retire
// HALT   | illegal-instruction trap, left only by reset
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] Da,
  input  logic        is_zero,
  output logic [31:0] pc,
  output logic        instr_req,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [31:0] new_PC,
  output logic [1:0]  regdst,
  output logic [2:0]  ALUcntrl,
  output logic        AlUsrc,
  output logic [1:0]  MemtoReg,
  output logic        RegWr,
  output logic        MemWr,
  output logic        retire,
  output logic        halted
);

`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic [31:0] pc_nxt;
  logic        branch_taken;
  ctrl_t       ctrl;

  core_decode u_decode (
    .ir   (ir),
    .ctrl (ctrl)
  );

  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign immediate = ir[15:0];
  assign new_PC    = pc + 32'd4;
  assign regdst    = ctrl.regdst;
  assign ALUcntrl  = ctrl.aluctrl;
  assign AlUsrc    = ctrl.alusrc;
  assign MemtoReg  = ctrl.memtoreg;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
      pc <= RESET_PC;
    end else begin
      if (state == ST_FETCH && instr_valid) ir <= instr;
      if (retire) pc <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH:  if (instr_valid) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (ctrl.illegal) state_nxt = TRAP_EN ? ST_HALT : ST_FETCH;
        else              state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if      (ctrl.need_mem) state_nxt = ST_MEM;
        else if (ctrl.need_wb)  state_nxt = ST_WB;
        else                    state_nxt = ST_FETCH;
      end
      ST_MEM:  state_nxt = ctrl.need_wb ? ST_WB : ST_FETCH;
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    instr_req = (state == ST_FETCH);
    RegWr     = (state == ST_WB);
    MemWr     = (state == ST_MEM) && ctrl.sw;
    retire    = 1'b0;
    unique case (state)
      ST_DECODE: retire = ctrl.illegal && !TRAP_EN;
      ST_EXEC:   retire = !ctrl.need_mem && !ctrl.need_wb;
      ST_MEM:    retire = !ctrl.need_wb;
      ST_WB:     retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  // is_zero is only meaningful in EXEC, which is the branch retiring cycle.
  assign branch_taken = ctrl.branch && (is_zero ^ ctrl.bne);

  always_comb begin
    pc_nxt = new_PC;
    if (branch_taken)   pc_nxt = new_PC + {{14{ir[15]}}, ir[15:0], 2'b00};
    else if (ctrl.jump) pc_nxt = {new_PC[31:28], ir[25:0], 2'b00};
    else if (ctrl.jr)   pc_nxt = Da;
  end

`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multicycle control unit for the register-file/ALU/data-memory core. It fetches a 32-bit MIPS-subset instruction over a valid-qualified fetch port, latches it in an instruction register, and steps the core through DECODE/EXEC/MEM/WB states. In each state it drives the core's register addresses, immediate, mux selects, ALU opcode and write enables, and it owns the PC and next-PC logic, including branches, jumps and link.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 32: fetched instruction word.
- `instr_valid` input 1: `instr` is valid this cycle. Sampled only in FETCH.
- `Da` input 32: core register-file port A, used by JR.
- `is_zero` input 1: core ALU zero flag.
- `pc` output 32: current PC, which is also the fetch address.
- `instr_req` output 1: high while in FETCH.
- `rs`, `rt`, `rd` output 5 each: IR[25:21], IR[20:16], IR[15:11].
- `immediate` output 16: IR[15:0].
- `new_PC` output 32: pc + 4, modulo 2^32.
- `regdst` output 2: 0 selects rd, 1 selects rt, 2 selects 31.
- `ALUcntrl` output 3: 0 ADD, 1 SUB, 2 XOR, 3 SLT.
- `AlUsrc` output 1: 0 selects register, 1 selects sign-extended immediate.
- `MemtoReg` output 2: 0 selects ALU, 1 selects memory, 2 selects `new_PC`.
- `RegWr`, `MemWr` output 1 each: single-cycle write pulses.
- `retire` output 1: one-cycle pulse when an instruction completes.
- `halted` output 1: see Configuration.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Hold while `instr_valid` = 0.
  - When `instr_valid` = 1, load the IR and go to DECODE.
- Supported instructions: LW, SW, J, JR, JAL, BEQ, BNE, ADDI, XORI; R-type ADD, SUB, SLT.
- Mux selects and `ALUcntrl` are combinational from the IR and are held stable from DECODE until the instruction retires.
- I-type (ADDI, XORI, LW, SW) sets `AlUsrc` = 1. ADDI, XORI and LW set `regdst` = 1.
- `RegWr` is high only in WB. `MemWr` is high only in MEM for SW.
- State paths:
  - R-type, ADDI, XORI: DECODE → EXEC → WB.
  - LW: DECODE → EXEC → MEM → WB, with `MemtoReg` = 1.
  - SW: DECODE → EXEC → MEM.
  - BEQ, BNE: DECODE → EXEC, with `ALUcntrl` = SUB. Taken when `is_zero` = 1 (BEQ) or `is_zero` = 0 (BNE), both sampled in EXEC.
  - J, JR: DECODE → EXEC.
  - JAL: DECODE → EXEC → WB, with `regdst` = 2 and `MemtoReg` = 2.
- PC update happens only on the retiring edge:
  - Default: pc + 4.
  - Taken branch: pc + 4 + (sext(imm) << 2).
  - J, JAL: {pc+4[31:28], IR[25:0], 2'b00}.
  - JR: `Da`.
- All PC arithmetic is 32-bit and wraps at 2^32.
- On retire, `retire` pulses and the FSM returns to FETCH.
- Any unlisted opcode or funct is illegal (see Configuration).

## Timing
- Reset values:
  - State = FETCH, `pc` = RESET_PC, IR = 0.
  - `instr_req` = 1.
  - `RegWr`, `MemWr`, `retire` and `halted` = 0.
  - Selects = 0.
- Reset asserted mid-instruction:
  - Aborts the instruction; no write pulse and no PC change take effect.
  - The first cycle after reset deasserts is FETCH.
- Cycles from `instr_valid` acceptance to retire, inclusive of the FETCH cycle:
  - 4: R-type, ADDI, XORI, SW, JAL.
  - 5: LW.
  - 3: BEQ, BNE, J, JR.
- FETCH with `instr_valid` held low stalls indefinitely; `pc` is unchanged during the stall.
- `instr_valid` outside FETCH is ignored.
- JAL writes the pre-jump `new_PC` to register 31 in WB; the PC changes on the same edge.

## Configuration
- `CORE_SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal instruction goes DECODE → HALT.
  - `halted` = 1, no writes occur, `instr_req` = 0, and the FSM stays in HALT until reset.
- `CORE_SEQ_ILLEGAL_TRAP_EN` undefined:
  - An illegal instruction retires as a NOP in DECODE (2 cycles): pc + 4, no writes.
  - `halted` is tied to 0.

## Structure
- Shared package `core_pkg`:
  - State enum.
  - Opcode/funct constants (LW 6'h23, SW 6'h2b, J 6'h02, JAL 6'h03, BEQ 6'h04, BNE 6'h05, ADDI 6'h08, XORI 6'h0e, R 6'h00; funct ADD 6'h20, SUB 6'h22, SLT 6'h2a, JR 6'h08).
  - ALU, regdst and MemtoReg encodings.
- Sub-module `core_decode`: combinational IR-to-control decoder, giving per-class path flags and selects. The FSM, IR and PC logic live in `core_sequencer`.

## Test plan
- **Reset with FETCH stall:** with RESET_PC = 0x100, hold `instr_valid` low for 5 cycles → `pc` = 0x100, `instr_req` = 1 and no write pulses throughout.
- **ADDI:** ADDI $8,$0,5 (0x20080005) → `RegWr` pulses exactly once, on cycle 4, with `regdst` = 1, `AlUsrc` = 1, `ALUcntrl` = 0; `pc` becomes 0x104.
- **LW then SW:** LW (0x8d090004) → `RegWr` on cycle 5 with `MemtoReg` = 1. Following SW (0xad090008) → `MemWr` on cycle 4, `RegWr` never asserted.
- **Branches:** BEQ with imm = 0xFFFF at pc = 0x100, `is_zero` = 1 → pc = 0x100. Same with `is_zero` = 0 → pc = 0x104. BNE with `is_zero` = 0 and imm = 2 → pc = 0x10C.
- **Jumps:** JAL 0x0C000040 at pc = 0x100 → `RegWr` pulses with `regdst` = 2, `MemtoReg` = 2, `new_PC` = 0x104; pc = 0x100. JR with `Da` = 0x200 → pc = 0x200 after 3 cycles.
- **Illegal opcode and reset mid-instruction:** opcode 6'h3f with the macro defined → `halted` = 1 and `instr_req` = 0 until reset; without the macro → pc + 4 after 2 cycles. Separately, assert `reset` during LW's MEM state → no `RegWr` pulse, and `pc` = RESET_PC.
